uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Bus master that shares the UART slave's TX port among NUM_REQ byte-stream requesters (console, debug monitor, trace unit, ...).
- Arbitrates round-robin and captures one byte per grant.
- Polls the UART status register until the TX FIFO is not full, then writes the byte to the TX port word.
- Sits on the system bus as a master, in front of the UART bus slave.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- UART_BASE, 0, word address of the UART slave on the bus. It equals the slave's start address.
- TIMEOUT, 255, maximum cycles to wait for ack/err on one access before aborting (8-bit counter).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ x 8  per-requester byte; stable while its valid is high.
- req_ready  out  NUM_REQ  one-cycle pulse: byte accepted (captured).
- bus_o  out  bus::m2s_s  master request (cyc, stb, we, sel, addr, data).
- bus_i  in  bus::s2m_s  slave response (data, ack, err, stall).
- busy  out  1  high whenever state != IDLE.
- err_sticky  out  1  set on any bus err or timeout; cleared by err_clr.
- err_clr  in  1  clears err_sticky; a set event in the same cycle wins.

Behaviour:
- Reset values: bus_o all zero, req_ready 0, busy 0, err_sticky 0, rr pointer 0, state IDLE.
- rst mid-transaction: cyc/stb drop the next cycle and the captured byte is lost. No req_ready is re-issued.
- FSM states: IDLE, ST_REQ, ST_WAIT, TX_REQ, TX_WAIT.
- IDLE:
  - If any req_valid is set, grant the first valid index at or after rr_ptr (wrapping modulo NUM_REQ).
  - Latch that requester's req_data into tx_byte.
  - Pulse req_ready[grant] this cycle.
  - Set rr_ptr = grant+1, wrapping to 0 when grant = NUM_REQ-1.
  - Go to ST_REQ.
  - Only one grant per cycle. Requesters not granted are unaffected.
- ST_REQ (status read):
  - cyc=1, stb=1, we=0, sel=4'hF, addr=UART_BASE+`UART_STATUS_REG_WORD.
  - Hold stb while bus_i.stall=1. On the cycle stall=0, go to ST_WAIT with stb=0 and cyc=1.
- ST_WAIT:
  - On ack:
    - If bus_i.data[`UART_TX_FIFO_FULL_BIT]=1, return to ST_REQ (re-poll, no back-off).
    - Otherwise go to TX_REQ.
  - On err or timeout: set err_sticky, drop cyc, return to IDLE. The byte is discarded.
  - ack and err together are treated as err.
- TX_REQ (TX write):
  - cyc=1, stb=1, we=1, sel=4'b0001, addr=UART_BASE+`UART_TX_PORT_WORD, data={24'h0,tx_byte}.
  - Same stall rule as ST_REQ, then go to TX_WAIT.
- TX_WAIT:
  - On ack: drop cyc, go to IDLE.
  - On err or timeout: set err_sticky, drop cyc, go to IDLE.
- Timeout counter:
  - Cleared on entry to ST_REQ/TX_REQ; counts every cycle in REQ/WAIT states.
  - Abort when it reaches TIMEOUT; saturates.
- Latency with a zero-stall, next-cycle-ack slave (the UART slave's behaviour):
  - Grant at cycle 0, status stb at 1, ack at 2, write stb at 3, ack at 4, IDLE at 5.
  - Next grant is possible at cycle 5, giving a throughput of one byte per 5 cycles.
- cyc stays asserted continuously from ST_REQ entry until the final ack/err. The status read and TX write are not one locked cycle; a polling re-read is allowed.
- bus_o.data is zero for reads. bus_o fields are zero in IDLE.
- Fairness: a requester holding valid continuously is granted at most once per NUM_REQ grants when others are also valid.

Decomposition:
- Shared package (existing bus package / uart_defines): register word offsets, TX_FIFO_FULL bit index, bus m2s/s2m typedefs (all existing).
- New in the bus package: an arb_state_e enum for the five states.
- One natural sub-module: rr_arbiter (parameterised NUM_REQ; inputs req vector, ptr; outputs one-hot grant and index), reusable by other bus masters.

Test Plan:
- Single byte: req_valid=4'b0001, req_data[0]=8'h41, UART model acks next cycle, status FULL=0 -> req_ready[0] pulses at cycle 0. Write at addr UART_BASE+TX_PORT_WORD carries data 32'h41, sel 4'b0001. busy drops at cycle 5.
- Round-robin: all four requesters valid continuously with bytes 8'hA0..8'hA3 -> TX writes in order A0,A1,A2,A3,A0, each 5 cycles apart.
- FIFO full: status returns FULL=1 for 3 polls then 0 -> exactly 4 status reads precede the single TX write, and the byte is unchanged.
- Stall: slave asserts stall for 2 cycles on the TX write -> stb and addr/data held for 3 cycles, cyc never drops, and exactly one write is accepted.
- Error/timeout: slave returns err on the status read -> err_sticky=1, no TX write, state IDLE. Next case: slave never acks -> abort after 255 cycles and err_sticky stays set. Then err_clr=1 -> err_sticky=0.
- Reset mid-write: rst asserted during TX_WAIT -> the next cycle has cyc=0, stb=0, busy=0, req_ready=0, and rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared bus and UART register definitions for the TX arbiter and its arbiter sub-block.
// Holds the bus request/response typedefs, the UART word offsets and the arbiter state encoding.
package uart_tx_arbiter_pkg;

   localparam logic [31:0] UART_TX_PORT_WORD     = 32'h0;
   localparam logic [31:0] UART_STATUS_REG_WORD  = 32'h1;
   localparam int unsigned UART_TX_FIFO_FULL_BIT = 3;

   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] data;
   } m2s_s;

   typedef struct packed {
      logic [31:0] data;
      logic        ack;
      logic        err;
      logic        stall;
   } s2m_s;

   typedef enum logic [2:0] {
      StIdle,
      StStReq,
      StStWait,
      StTxReq,
      StTxWait
   } arb_state_e;

   function automatic m2s_s status_rd(input logic [31:0] base);
      m2s_s m;
      m      = '0;
      m.cyc  = 1'b1;
      m.stb  = 1'b1;
      m.sel  = 4'hF;
      m.addr = base + UART_STATUS_REG_WORD;
      return m;
   endfunction

   function automatic m2s_s tx_wr(input logic [31:0] base, input logic [7:0] b);
      m2s_s m;
      m      = '0;
      m.cyc  = 1'b1;
      m.stb  = 1'b1;
      m.we   = 1'b1;
      m.sel  = 4'b0001;
      m.addr = base + UART_TX_PORT_WORD;
      m.data = {24'h0, b};
      return m;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping modulo NUM_REQ.
// Purely combinational; the owner keeps the pointer register.
module uart_tx_arbiter_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IdxW-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IdxW-1:0]    idx_o,
   output logic               valid_o
);

   int j;

   // Scan from the farthest offset down so the nearest valid requester wins.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      j       = 0;
      for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
         j = int'(ptr_i) + off;
         if (j >= int'(NUM_REQ)) begin
            j = j - int'(NUM_REQ);
         end
         if (req_i[j]) begin
            gnt_o    = '0;
            gnt_o[j] = 1'b1;
            idx_o    = IdxW'(j);
            valid_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Bus master sharing the UART TX port among NUM_REQ byte requesters: grant round-robin,
// poll the status word until the TX FIFO has room, then write the captured byte.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter logic [31:0] UART_BASE = 32'h0,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output m2s_s                 bus_o,
   input  s2m_s                 bus_i,
   output logic                 busy,
   output logic                 err_sticky,
   input  logic                 err_clr
);

   localparam int unsigned IdxW   = $clog2(NUM_REQ);
   localparam logic [7:0]  TmoMax = 8'(TIMEOUT);

   arb_state_e          state_q;
   m2s_s                bus_q;
   logic [IdxW-1:0]     rr_q;
   logic [IdxW-1:0]     rr_next;
   logic [IdxW-1:0]     gnt_idx;
   logic [NUM_REQ-1:0]  gnt;
   logic                gnt_valid;
   logic [7:0]          tx_byte_q;
   logic [7:0]          tmo_q;
   logic                err_q;
   logic                tmo_hit;
   logic                abort;
   logic                fifo_full;
   logic                unused_bus;

   uart_tx_arbiter_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IdxW    (IdxW)
   ) u_rr (
      .req_i   (req_valid),
      .ptr_i   (rr_q),
      .gnt_o   (gnt),
      .idx_o   (gnt_idx),
      .valid_o (gnt_valid)
   );

   assign tmo_hit    = (tmo_q == TmoMax);
   assign fifo_full  = bus_i.data[UART_TX_FIFO_FULL_BIT];
   assign unused_bus = ^bus_i.data;
   assign rr_next    = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

   // An err wins over a simultaneous ack; a late ack wins over the timeout.
   always_comb begin
      abort = 1'b0;
      unique case (state_q)
         StStReq, StTxReq:   abort = tmo_hit;
         StStWait, StTxWait: abort = bus_i.err | (~bus_i.ack & tmo_hit);
         default:            abort = 1'b0;
      endcase
   end

   assign req_ready  = (state_q == StIdle) ? gnt : '0;
   assign busy       = (state_q != StIdle);
   assign err_sticky = err_q;
   assign bus_o      = bus_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         bus_q     <= '0;
         rr_q      <= '0;
         tx_byte_q <= '0;
         tmo_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         if (abort) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end

         if (abort) begin
            bus_q   <= '0;
            state_q <= StIdle;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (gnt_valid) begin
                     tx_byte_q <= req_data[{gnt_idx, 3'b000} +: 8];
                     rr_q      <= rr_next;
                     tmo_q     <= '0;
                     bus_q     <= status_rd(UART_BASE);
                     state_q   <= StStReq;
                  end
               end
               StStReq: begin
                  tmo_q <= tmo_q + 8'd1;
                  if (!bus_i.stall) begin
                     bus_q.stb <= 1'b0;
                     state_q   <= StStWait;
                  end
               end
               StStWait: begin
                  if (bus_i.ack) begin
                     tmo_q <= '0;
                     if (fifo_full) begin
                        bus_q   <= status_rd(UART_BASE);
                        state_q <= StStReq;
                     end else begin
                        bus_q   <= tx_wr(UART_BASE, tx_byte_q);
                        state_q <= StTxReq;
                     end
                  end else begin
                     tmo_q <= tmo_q + 8'd1;
                  end
               end
               StTxReq: begin
                  tmo_q <= tmo_q + 8'd1;
                  if (!bus_i.stall) begin
                     bus_q.stb <= 1'b0;
                     state_q   <= StTxWait;
                  end
               end
               StTxWait: begin
                  if (bus_i.ack) begin
                     bus_q   <= '0;
                     state_q <= StIdle;
                  end else begin
                     tmo_q <= tmo_q + 8'd1;
                  end
               end
               default: begin
                  bus_q   <= '0;
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small reactive UART slave model.
module tb_uart_tx_arbiter;
   import uart_tx_arbiter_pkg::*;

   localparam logic [31:0] BASE      = 32'h40;
   localparam logic [31:0] ST_ADDR   = BASE + UART_STATUS_REG_WORD;
   localparam logic [31:0] TX_ADDR   = BASE + UART_TX_PORT_WORD;
   localparam logic [31:0] FULL_WORD = 32'h1 << UART_TX_FIFO_FULL_BIT;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   m2s_s        bus_o;
   s2m_s        bus_i;
   logic        busy;
   logic        err_sticky;
   logic        err_clr;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ   (4),
      .UART_BASE (BASE),
      .TIMEOUT   (255)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .bus_o      (bus_o),
      .bus_i      (bus_i),
      .busy       (busy),
      .err_sticky (err_sticky),
      .err_clr    (err_clr)
   );

   // Slave configuration, written only by the stimulus process.
   int full_polls = 0;
   int stall_cfg  = 0;
   bit err_mode   = 1'b0;
   bit no_ack     = 1'b0;

   // Slave/monitor state, written only by the model process.
   int          rd_cnt = 0, wr_cnt = 0, cyc_cnt = 0, rd_in_txn = 0, stall_seen = 0;
   int          wr_stb_cycles = 0, gap_cnt = 0, bad_hold = 0;
   logic [7:0]  wr_byte [64];
   int          wr_at [64];
   logic        s_ack = 1'b0, s_err = 1'b0;
   logic [31:0] s_rdata = '0;
   logic        acc;

   always_comb begin
      bus_i       = '0;
      bus_i.ack   = s_ack;
      bus_i.err   = s_err;
      bus_i.data  = s_rdata;
      bus_i.stall = bus_o.cyc && bus_o.stb && bus_o.we && (stall_seen < stall_cfg);
   end

   assign acc = bus_o.cyc && bus_o.stb && !bus_i.stall;

   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      s_ack   <= acc && !no_ack && !(err_mode && !bus_o.we);
      s_err   <= acc && err_mode && !bus_o.we;
      s_rdata <= (acc && !bus_o.we && rd_in_txn < full_polls) ? FULL_WORD : 32'h0;
      if (!bus_o.cyc) begin
         rd_in_txn  <= 0;
         stall_seen <= 0;
      end else if (bus_o.stb && bus_i.stall) begin
         stall_seen <= stall_seen + 1;
      end
      if (acc && bus_o.we) begin
         wr_byte[wr_cnt % 64] <= bus_o.data[7:0];
         wr_at[wr_cnt % 64]   <= cyc_cnt;
         wr_cnt               <= wr_cnt + 1;
      end
      if (acc && !bus_o.we) begin
         rd_cnt    <= rd_cnt + 1;
         rd_in_txn <= rd_in_txn + 1;
      end
      if (bus_o.stb && bus_o.we) begin
         wr_stb_cycles <= wr_stb_cycles + 1;
         if (bus_o.addr != TX_ADDR || bus_o.data[31:8] != 24'h0 || !bus_o.cyc) begin
            bad_hold <= bad_hold + 1;
         end
      end
      if (busy && !bus_o.cyc) gap_cnt <= gap_cnt + 1;
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while (busy && k < budget) begin
         tick();
         k++;
      end
      check({tag, " idle within budget"}, 32'(busy), 32'h0);
   endtask

   // Present one byte at an idle negedge, expect the same-cycle ready, then withdraw.
   task automatic send(input int idx, input logic [7:0] b, input string tag);
      req_data[idx*8 +: 8] = b;
      req_valid            = 4'(1 << idx);
      #1;
      check({tag, " req_ready"}, 32'(req_ready), 32'(1 << idx));
      tick();
      req_valid = '0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w0, r0, s0, b0, g0, k;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      err_clr   = 1'b0;
      tick(3);

      check("rst bus_o zero", 32'(bus_o == '0), 32'h1);
      check("rst req_ready", 32'(req_ready), 32'h0);
      check("rst busy", 32'(busy), 32'h0);
      check("rst err_sticky", 32'(err_sticky), 32'h0);
      rst = 1'b0;
      tick();

      // Single byte, checked cycle by cycle.
      w0 = wr_cnt;
      send(0, 8'h41, "t1");
      check("t1 c1 stb", 32'(bus_o.stb), 32'h1);
      check("t1 c1 we", 32'(bus_o.we), 32'h0);
      check("t1 c1 addr", bus_o.addr, ST_ADDR);
      check("t1 c1 sel", 32'(bus_o.sel), 32'hF);
      check("t1 c1 data", bus_o.data, 32'h0);
      tick();
      check("t1 c2 stb", 32'(bus_o.stb), 32'h0);
      check("t1 c2 cyc", 32'(bus_o.cyc), 32'h1);
      tick();
      check("t1 c3 stb", 32'(bus_o.stb), 32'h1);
      check("t1 c3 we", 32'(bus_o.we), 32'h1);
      check("t1 c3 addr", bus_o.addr, TX_ADDR);
      check("t1 c3 sel", 32'(bus_o.sel), 32'h1);
      check("t1 c3 data", bus_o.data, 32'h41);
      tick();
      check("t1 c4 busy", 32'(busy), 32'h1);
      tick();
      check("t1 c5 busy", 32'(busy), 32'h0);
      check("t1 c5 cyc", 32'(bus_o.cyc), 32'h0);
      check("t1 writes", 32'(wr_cnt - w0), 32'h1);

      // Round-robin with all four valid from a fresh pointer.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      w0        = wr_cnt;
      req_data  = 32'hA3A2A1A0;
      req_valid = 4'hF;
      #1;
      check("t2 first grant", 32'(req_ready), 32'h1);
      tick(21);
      req_valid = '0;
      wait_idle("t2", 20);
      check("t2 writes", 32'(wr_cnt - w0), 32'h5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t2 byte%0d", i), 32'(wr_byte[(w0 + i) % 64]), 32'(8'hA0 + (i % 4)));
         if (i > 0) begin
            check($sformatf("t2 spacing%0d", i),
                  32'(wr_at[(w0 + i) % 64] - wr_at[(w0 + i - 1) % 64]), 32'h5);
         end
      end

      // FIFO full for three polls.
      full_polls = 3;
      r0 = rd_cnt;
      w0 = wr_cnt;
      send(2, 8'h5A, "t3");
      wait_idle("t3", 60);
      full_polls = 0;
      check("t3 status reads", 32'(rd_cnt - r0), 32'h4);
      check("t3 writes", 32'(wr_cnt - w0), 32'h1);
      check("t3 byte", 32'(wr_byte[w0 % 64]), 32'h5A);
      check("t3 err", 32'(err_sticky), 32'h0);

      // Two stall cycles on the TX write.
      stall_cfg = 2;
      s0 = wr_stb_cycles;
      b0 = bad_hold;
      g0 = gap_cnt;
      w0 = wr_cnt;
      send(3, 8'hC3, "t4");
      wait_idle("t4", 30);
      stall_cfg = 0;
      check("t4 write stb cycles", 32'(wr_stb_cycles - s0), 32'h3);
      check("t4 held addr/data", 32'(bad_hold - b0), 32'h0);
      check("t4 cyc gaps", 32'(gap_cnt - g0), 32'h0);
      check("t4 writes", 32'(wr_cnt - w0), 32'h1);
      check("t4 byte", 32'(wr_byte[w0 % 64]), 32'hC3);

      // Error on status read.
      err_mode = 1'b1;
      w0 = wr_cnt;
      send(0, 8'h11, "t5a");
      wait_idle("t5a", 20);
      err_mode = 1'b0;
      check("t5a err_sticky", 32'(err_sticky), 32'h1);
      check("t5a writes", 32'(wr_cnt - w0), 32'h0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t5a err cleared", 32'(err_sticky), 32'h0);

      // Slave never acks: abort after the full timeout.
      no_ack = 1'b1;
      w0 = wr_cnt;
      send(1, 8'h22, "t5b");
      k = 1;
      while (busy && k < 400) begin
         tick();
         k++;
      end
      no_ack = 1'b0;
      check("t5b abort cycle", 32'(k), 32'd257);
      check("t5b err_sticky", 32'(err_sticky), 32'h1);
      check("t5b writes", 32'(wr_cnt - w0), 32'h0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t5b err cleared", 32'(err_sticky), 32'h0);

      // Reset during TX_WAIT.
      send(1, 8'h77, "t6");
      tick(3);
      check("t6 busy before rst", 32'(busy), 32'h1);
      rst = 1'b1;
      tick();
      check("t6 cyc", 32'(bus_o.cyc), 32'h0);
      check("t6 stb", 32'(bus_o.stb), 32'h0);
      check("t6 busy", 32'(busy), 32'h0);
      check("t6 req_ready", 32'(req_ready), 32'h0);
      rst       = 1'b0;
      req_data  = 32'h44332211;
      req_valid = 4'hF;
      #1;
      check("t6 ptr reset grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      wait_idle("t6", 20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
